// File: rtl/microwave_pkg.sv
// Shared widths, FSM state encoding and key-code helpers for the microwave
// front-end blocks.
package microwave_pkg;

  localparam int KEY_W   = 10;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_t;

  // Only ever applied to one-hot codes, so the OR-merge yields the single index.
  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] code);
    logic [DIGIT_W-1:0] bcd;
    bcd = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (code[i]) bcd = bcd | DIGIT_W'(i);
    end
    return bcd;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_gt1(input logic [KEY_W-1:0] code);
    return (code & (code - KEY_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-high clear.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/keypad_encoder.sv
// Debounces the raw 10-line keypad and emits one BCD digit strobe per
// physical press; second keys pressed during a hold are ignored.
module keypad_encoder
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [KEY_W-1:0]   keypad,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  output logic               key_held,
  output logic               multi_key,
  output kp_state_t          o_dbg_state
);

  // digit_valid is a one-cycle strobe with no back-pressure: the consumer
  // must take digit on the cycle digit_valid is high; digit then holds.

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0]   w_ks;
  logic               w_none;
  logic               w_multi;
  logic               w_one;

  kp_state_t          r_state;
  logic [3:0]         r_cnt;
  logic [KEY_W-1:0]   r_cand;
  logic [DIGIT_W-1:0] r_digit;
  logic               r_valid;
  logic               r_held;
  logic               r_multi;

  for (genvar g = 0; g < KEY_W; g++) begin : g_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .clear (clear),
      .i_d   (keypad[g]),
      .o_q   (w_ks[g])
    );
  end

  assign w_none  = (w_ks == '0);
  assign w_multi = popcount_gt1(w_ks);
  assign w_one   = !w_none && !w_multi;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_digit <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_multi <= w_multi;
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_one) begin
            r_cand  <= w_ks;
            r_cnt   <= 4'd1;
            r_state <= ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (w_ks == r_cand) begin
            if (r_cnt == CNT_LAST) begin
              r_digit <= onehot_to_bcd(r_cand);
              r_valid <= 1'b1;
              r_held  <= 1'b1;
              r_state <= ST_HELD;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HELD: begin
          // Any nonzero pattern keeps the hold; no rollover to a second key.
          if (w_none) begin
            r_cnt   <= 4'd1;
            r_state <= ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (w_none) begin
            if (r_cnt == CNT_LAST) begin
              r_held  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_state <= ST_HELD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_valid;
  assign key_held    = r_held;
  assign multi_key   = r_multi;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: latency, debounce, multi-key, hold
// lockout and mid-operation clear, with a strobe scoreboard.
module tb_keypad_encoder;
  import microwave_pkg::*;

  logic               clk;
  logic               clear;
  logic [KEY_W-1:0]   keypad;
  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic               key_held;
  logic               multi_key;
  kp_state_t          dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DIGIT_W-1:0] exp_q[$];
  logic [DIGIT_W-1:0] got_q[$];
  int                 stb_cyc_q[$];

  keypad_encoder #(.DEBOUNCE_CYCLES(3), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .clear       (clear),
    .keypad      (keypad),
    .digit       (digit),
    .digit_valid (digit_valid),
    .key_held    (key_held),
    .multi_key   (multi_key),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor feeding the scoreboard
  always @(negedge clk) begin
    if (digit_valid) begin
      got_q.push_back(digit);
      stb_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_drain(input string tag);
    check({tag, "_strobe_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_strobe_digit"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
    stb_cyc_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_digit"},    32'(digit),       32'd0);
    check({tag, "_valid"},    32'(digit_valid), 32'd0);
    check({tag, "_held"},     32'(key_held),    32'd0);
    check({tag, "_multi"},    32'(multi_key),   32'd0);
    check({tag, "_state"},    32'(dbg_state),   32'(ST_IDLE));
  endtask

  initial begin
    int gap;
    clear  = 1'b1;
    keypad = '0;
    tick(2);
    check_cleared("rst");
    clear = 1'b0;

    // idle after reset
    tick(20);
    check_cleared("idle");
    sb_drain("idle");

    // clean press of key 2: strobe on the 5th edge after the change
    keypad = 10'b0000000100;
    tick(4);
    check("k2_pre_valid", 32'(digit_valid), 32'd0);
    check("k2_pre_held",  32'(key_held),    32'd0);
    tick(1);
    exp_q.push_back(4'd2);
    check("k2_valid", 32'(digit_valid), 32'd1);
    check("k2_digit", 32'(digit),       32'd2);
    check("k2_held",  32'(key_held),    32'd1);
    tick(1);
    check("k2_valid_drop", 32'(digit_valid), 32'd0);
    tick(104);
    check("k2_still_held", 32'(key_held), 32'd1);
    keypad = '0;
    tick(4);
    check("k2_rel_pre_held", 32'(key_held), 32'd1);
    tick(1);
    check("k2_rel_held",  32'(key_held), 32'd0);
    check("k2_rel_digit", 32'(digit),    32'd2);
    tick(10);
    check("k2_digit_hold", 32'(digit), 32'd2);
    sb_drain("k2");

    // bounce on key 3, then steady
    for (int i = 0; i < 10; i++) begin
      keypad = (i % 2 == 0) ? 10'b0000001000 : 10'b0000000000;
      tick(1);
    end
    check("bounce_no_strobe", 32'(got_q.size()), 32'd0);
    keypad = 10'b0000001000;
    tick(4);
    check("k3_pre_valid", 32'(digit_valid), 32'd0);
    tick(1);
    exp_q.push_back(4'd3);
    check("k3_valid", 32'(digit_valid), 32'd1);
    check("k3_digit", 32'(digit),       32'd3);
    tick(15);
    keypad = '0;
    tick(10);
    sb_drain("k3");

    // two keys at once: flagged, never accepted
    keypad = 10'b0000100010;
    tick(2);
    check("multi_pre", 32'(multi_key), 32'd0);
    tick(1);
    check("multi_set",   32'(multi_key), 32'd1);
    check("multi_state", 32'(dbg_state), 32'(ST_IDLE));
    tick(17);
    check("multi_no_strobe", 32'(got_q.size()), 32'd0);
    keypad = 10'b0000000010;
    tick(5);
    exp_q.push_back(4'd1);
    check("k1_valid", 32'(digit_valid), 32'd1);
    check("k1_digit", 32'(digit),       32'd1);
    check("k1_multi", 32'(multi_key),   32'd0);
    tick(5);
    // key 5 joins while key 1 is held: ignored
    keypad = 10'b0000100010;
    tick(10);
    check("k5_held",  32'(key_held),  32'd1);
    check("k5_digit", 32'(digit),     32'd1);
    check("k5_multi", 32'(multi_key), 32'd1);
    check("k5_state", 32'(dbg_state), 32'(ST_HELD));
    keypad = '0;
    tick(10);
    check("k1_rel_held", 32'(key_held), 32'd0);
    sb_drain("multi");

    // "2" then "3", 110-cycle holds and gaps
    keypad = 10'b0000000100;
    exp_q.push_back(4'd2);
    tick(110);
    keypad = '0;
    tick(110);
    keypad = 10'b0000001000;
    exp_q.push_back(4'd3);
    tick(110);
    keypad = '0;
    tick(110);
    gap = (stb_cyc_q.size() == 2) ? (stb_cyc_q[1] - stb_cyc_q[0]) : -1;
    check("seq_gap", 32'(gap), 32'd220);
    sb_drain("seq");

    // clear during PRESS_DB with key 7 held
    keypad = 10'b0010000000;
    tick(3);
    check("k7_press_state", 32'(dbg_state), 32'(ST_PRESS_DB));
    #2 clear = 1'b1;
    #1 check_cleared("clr_press");
    @(negedge clk) clear = 1'b0;
    tick(4);
    check("k7_pre_valid", 32'(digit_valid), 32'd0);
    tick(1);
    exp_q.push_back(4'd7);
    check("k7_valid", 32'(digit_valid), 32'd1);
    check("k7_digit", 32'(digit),       32'd7);
    tick(3);
    check("k7_held_state", 32'(dbg_state), 32'(ST_HELD));
    // clear during HELD
    #2 clear = 1'b1;
    #1 check_cleared("clr_held");
    @(negedge clk) clear = 1'b0;
    tick(5);
    exp_q.push_back(4'd7);
    check("k7b_valid", 32'(digit_valid), 32'd1);
    check("k7b_digit", 32'(digit),       32'd7);
    check("k7b_held",  32'(key_held),    32'd1);
    keypad = '0;
    tick(10);
    check("k7b_rel_held", 32'(key_held), 32'd0);
    sb_drain("clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
